// File: rtl/add_if.sv
// add_if: handshake bundle for add_responder.
//   master : drives operands (in_valid, a, b) and the consumer strobe (out_ready)
//   slave  : drives in_ready, out_valid, y (WIDTH+1 bits) and count (16 bits)
interface add_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   y;
  logic [15:0]      count;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, count
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, count
  );
endinterface

// File: rtl/add_responder.sv
// add_responder: accepts unsigned operand pairs, buffers their full-width sums
// in a DEPTH-entry FIFO and returns them in acceptance order.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : add_if slave modport
//          in_valid/in_ready/a/b    operand handshake
//          out_valid/out_ready/y    result handshake (y = 0 while idle)
//          count                    results delivered, wraps at 16 bits
//
// state     | meaning
// ----------+--------------------------------
// S_EMPTY   | no results buffered
// S_PARTIAL | 0 < occupancy < DEPTH
// S_FULL    | occupancy == DEPTH, in_ready low
module add_responder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input logic  clk,
  input logic  rst,
  add_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
  localparam logic [OW-1:0] OCC_LAST = OW'(DEPTH - 1);
  localparam logic [OW-1:0] OCC_ONE  = OW'(1);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t          state_q;
  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic            out_valid_q, out_valid_d;
  logic [WIDTH:0]  y_q, y_d;
  logic [15:0]     count_q, count_d;

  logic            in_ready_w;
  logic            push;
  logic            pop;
  logic [WIDTH:0]  sum;

  // Ready depends only on registered occupancy, so a full buffer never
  // accepts even when a pop happens on the same edge.
  assign in_ready_w = (occ_q < OCC_FULL);
  assign push       = bus.in_valid && in_ready_w;
  assign pop        = out_valid_q && bus.out_ready;
  assign sum        = {1'b0, bus.a} + {1'b0, bus.b};

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    occ_d       = occ_q;
    count_d     = count_q + 16'(pop);
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
    out_valid_d = (occ_d != '0);
    // The new head is the incoming sum when nothing older survives this edge;
    // storage is written on the same edge, so bypass it.
    if (occ_d == '0)
      y_d = '0;
    else if (push && (occ_q == OW'(pop)))
      y_d = sum;
    else
      y_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wr_ptr_q] <= sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      count_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      count_q     <= count_d;
      case (state_q)
        S_EMPTY: begin
          if (push)
            state_q <= S_PARTIAL;
        end
        S_PARTIAL: begin
          if (push && !pop && (occ_q == OCC_LAST))
            state_q <= S_FULL;
          else if (pop && !push && (occ_q == OCC_ONE))
            state_q <= S_EMPTY;
        end
        S_FULL: begin
          if (pop)
            state_q <= S_PARTIAL;
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_add_responder.sv
// tb_add_responder: directed stimulus for add_responder with a queue-based
// reference model compared on every falling edge, plus literal spot checks.
module tb_add_responder;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  add_if #(.WIDTH(WIDTH)) bus ();

  add_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int q[$];
  int mcount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of sums with a delivered-results counter.
  always @(posedge clk) begin
    bit do_pop, do_push;
    int s;
    if (rst) begin
      q.delete();
      mcount = 0;
    end else begin
      do_pop  = (q.size() > 0) && (bus.out_ready === 1'b1);
      do_push = (bus.in_valid === 1'b1) && (q.size() < DEPTH);
      s = int'(bus.a) + int'(bus.b);
      if (do_pop) begin
        void'(q.pop_front());
        mcount = (mcount + 1) % 65536;
      end
      if (do_push)
        q.push_back(s);
    end
  end

  always @(negedge clk) begin
    check("model_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    check("model_y", 32'(bus.y), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    check("model_in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    check("model_count", 32'(bus.count), 32'(mcount));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int av, input int bv);
    bus.in_valid = v;
    bus.a = 4'(av);
    bus.b = 4'(bv);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 0);
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_y", 32'(bus.y), 32'd0);
    check("reset_count", 32'(bus.count), 32'd0);
    rst = 1'b0;
    tick();
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    // basic stream with consumer always ready
    bus.out_ready = 1'b1;
    drive(1'b1, 1, 3); tick(); check("basic_y0", 32'(bus.y), 32'd4);
    drive(1'b1, 5, 6); tick(); check("basic_y1", 32'(bus.y), 32'd11);
    drive(1'b1, 7, 8); tick(); check("basic_y2", 32'(bus.y), 32'd15);
    drive(1'b0, 0, 0); tick();
    check("basic_count", 32'(bus.count), 32'd3);
    check("basic_drained", 32'(bus.out_valid), 32'd0);

    // maximum operands
    drive(1'b1, 15, 15); tick(); check("max_y", 32'(bus.y), 32'd30);
    drive(1'b0, 0, 0); tick();

    // fill the buffer with the consumer stalled
    bus.out_ready = 1'b0;
    drive(1'b1, 3, 11); tick();
    drive(1'b1, 4, 9);  tick();
    drive(1'b1, 4, 1);  tick();
    drive(1'b1, 10, 12); tick();
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 11, 9); tick();
    check("full_reject_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_hold_y", 32'(bus.y), 32'd14);
    bus.out_ready = 1'b1;
    tick(); check("full_y1", 32'(bus.y), 32'd13);
    tick(); drive(1'b0, 0, 0); check("full_y2", 32'(bus.y), 32'd5);
    tick(); check("full_y3", 32'(bus.y), 32'd22);
    tick(); check("full_y4", 32'(bus.y), 32'd20);
    tick();
    check("full_drained", 32'(bus.out_valid), 32'd0);
    check("full_count", 32'(bus.count), 32'd9);

    // simultaneous push/pop at occupancy 2
    bus.out_ready = 1'b0;
    drive(1'b1, 1, 1); tick();
    drive(1'b1, 2, 2); tick();
    check("simul_head", 32'(bus.y), 32'd2);
    bus.out_ready = 1'b1;
    drive(1'b1, 3, 3); tick();
    check("simul_y", 32'(bus.y), 32'd4);
    drive(1'b0, 0, 0);
    bus.out_ready = 1'b0;
    tick();
    check("simul_hold", 32'(bus.y), 32'd4);
    bus.out_ready = 1'b1;
    tick(); check("simul_tail", 32'(bus.y), 32'd6);
    tick();
    check("simul_drained", 32'(bus.out_valid), 32'd0);
    check("simul_count", 32'(bus.count), 32'd12);

    // reset with three entries buffered
    bus.out_ready = 1'b0;
    drive(1'b1, 1, 2); tick();
    drive(1'b1, 2, 3); tick();
    drive(1'b1, 3, 4); tick();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 5, 5);
    tick();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_y", 32'(bus.y), 32'd0);
    check("midrst_count", 32'(bus.count), 32'd0);
    rst = 1'b0;
    drive(1'b0, 0, 0);
    bus.out_ready = 1'b0;
    tick();
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_empty", 32'(bus.out_valid), 32'd0);

    // 65536 handshakes bring count back to zero
    bus.out_ready = 1'b1;
    drive(1'b1, 9, 6);
    for (int i = 0; i < 65536; i++) tick();
    drive(1'b0, 0, 0);
    check("wrap_pre", 32'(bus.count), 32'hFFFF);
    tick();
    check("wrap_zero", 32'(bus.count), 32'd0);
    check("wrap_drained", 32'(bus.out_valid), 32'd0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/add_responder.md
ADD_RESPONDER -- requirements
Module: add_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, result buffer entries; power of two and >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair on a/b is valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port a  input  WIDTH  first operand, unsigned.
REQ-008 SHALL have port b  input  WIDTH  second operand, unsigned.
REQ-009 SHALL have port out_valid  output  1  y holds a valid result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts y this cycle.
REQ-011 SHALL have port y  output  WIDTH+1  sum result, unsigned.
REQ-012 SHALL have port count  output  16  number of results delivered.

Function
REQ-013 SHALL define input handshake as in_valid && in_ready at a rising edge; a/b are sampled only then.
REQ-014 SHALL compute a+b at full WIDTH+1 width with no truncation or saturation (WIDTH=4: max 15+15=30).
REQ-015 SHALL write each accepted sum into a DEPTH-entry FIFO in acceptance order.
REQ-016 SHALL assert out_valid on the cycle after acceptance at the earliest (1-cycle latency into an empty buffer).
REQ-017 SHALL define output handshake as out_valid && out_ready at a rising edge; the head entry is removed then.
REQ-018 SHALL drive y from the FIFO head while out_valid=1, and drive y=0 while out_valid=0.
REQ-019 SHALL hold y and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL drive in_ready = (occupancy < DEPTH), combinationally from registered occupancy; no pass-through when full, even with a simultaneous pop.
REQ-021 SHALL leave occupancy unchanged on a simultaneous push and pop (0 < occupancy < DEPTH).
REQ-022 SHALL wrap read and write pointers modulo DEPTH.
REQ-023 SHALL keep a state register: EMPTY (occ=0), PARTIAL (0<occ<DEPTH), FULL (occ=DEPTH).
REQ-024 SHALL transition EMPTY->PARTIAL on push; PARTIAL->FULL on push-only reaching DEPTH; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop-only reaching 0; otherwise hold.
REQ-025 SHALL ignore a pop attempt in EMPTY (out_valid=0) and a push attempt in FULL (in_ready=0) with no state change.
REQ-026 SHALL increment count by 1 per output handshake, wrapping 0xFFFF->0x0000.

Reset
REQ-027 SHALL, on any rising edge with rst=1, set occupancy=0, pointers=0, state=EMPTY, count=0, out_valid=0, y=0.
REQ-028 SHALL give in_ready=1 in the cycle after reset release.
REQ-029 SHALL ignore in_valid/out_ready while rst=1; reset mid-stream discards all buffered results.
REQ-030 SHALL not require resetting FIFO storage contents.

Verification
REQ-031 SHALL cover basic: reset, out_ready=1, push (1,3),(5,6),(7,8) on consecutive cycles -> y=4,11,15 on the next three cycles, count=3.
REQ-032 SHALL cover max operands: push (15,15) -> y=30 (5'b11110), no overflow.
REQ-033 SHALL cover full: out_ready=0, push (3,11),(4,9),(4,1),(10,12) -> state FULL, in_ready=0; a fifth push (11,9) with in_valid=1 is not accepted; then out_ready=1 -> y=14,13,5,22 in order, then 20 once re-offered.
REQ-034 SHALL cover simultaneous push/pop at occupancy 2 -> occupancy stays 2, order preserved.
REQ-035 SHALL cover reset mid-stream: 3 entries buffered, rst=1 one cycle -> out_valid=0, y=0, count=0, in_ready=1 next cycle.
REQ-036 SHALL cover count wrap: preload via 65536 handshakes -> count returns to 0x0000.
